// File: rtl/fp_align_shifter.sv
// Iterative right-shift alignment unit for the FPU adder path.
// Shifts {mant,GR} right by up to STEP bits per cycle, accumulating a sticky bit.
module fp_align_shifter #(
  parameter int unsigned IN_WIDTH    = 11,
  parameter int unsigned SHAMT_WIDTH = 5,
  parameter int unsigned STEP        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_mant,
  input  logic [SHAMT_WIDTH-1:0] in_shamt,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IN_WIDTH+1:0]    out_mant,
  output logic                   out_sticky,
  output logic                   out_zero
);

  localparam int unsigned W  = IN_WIDTH + 2;
  localparam int unsigned RW = SHAMT_WIDTH + 1;
  localparam logic [RW-1:0] W_R    = RW'(W);
  localparam logic [RW-1:0] STEP_R = RW'(STEP);
  localparam logic [W-1:0]  ONES   = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  acc, acc_nxt;
  logic          sticky, sticky_nxt;
  logic [RW-1:0] rem, rem_nxt;

  logic [RW-1:0] shamt_ext, shamt_clamped, s;
  logic [W-1:0]  mask;

  always_comb begin
    shamt_ext     = {1'b0, in_shamt};
    // Shifting past the full width only moves everything into sticky.
    shamt_clamped = (shamt_ext > W_R) ? W_R : shamt_ext;
    s             = (rem > STEP_R) ? STEP_R : rem;
    mask          = ~(ONES << s);
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    sticky_nxt = sticky;
    rem_nxt    = rem;
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_nxt    = {in_mant, 2'b00};
          sticky_nxt = 1'b0;
          rem_nxt    = shamt_clamped;
          state_nxt  = (shamt_clamped == '0) ? HOLD : SHIFT;
        end
      end
      SHIFT: begin
        sticky_nxt = sticky | (|(acc & mask));
        acc_nxt    = acc >> s;
        rem_nxt    = rem - s;
        if (rem == s) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt  = IDLE;
      acc_nxt    = '0;
      sticky_nxt = 1'b0;
      rem_nxt    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      sticky <= 1'b0;
      rem    <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      sticky <= sticky_nxt;
      rem    <= rem_nxt;
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == HOLD);
  assign out_mant   = acc;
  assign out_sticky = sticky;
  assign out_zero   = (acc == '0) && !sticky;

endmodule
